pio_uart_cmd_tx: RTL



---
 rtl/wifi_pkg.sv | 23 ++
 rtl/uart_bit_timer.sv | 28 ++
 rtl/pio_uart_cmd_tx.sv | 137 +++++++++++++
 3 files changed

// File: rtl/wifi_pkg.sv
// Shared definitions for the wifi UART path: FSM states, PIO command and status field positions.
package wifi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  localparam int unsigned REQ_BIT         = 31;
  localparam int unsigned CNT_HI          = 25;
  localparam int unsigned CNT_LO          = 24;
  localparam int unsigned PAYLOAD_W       = 24;
  localparam int unsigned STATUS_BUSY_BIT = 31;
  localparam int unsigned STATUS_ACK_BIT  = 30;

  // The payload only holds three bytes, so a count field of 3 means "three bytes" (bytes_left 2).
  function automatic logic [1:0] clamp_count(input logic [1:0] cnt);
    return (cnt == 2'd3) ? 2'd2 : cnt;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/pio_uart_cmd_tx.sv
// Toggle-handshake PIO command to UART 8N1 transmitter: sends 1-3 payload bytes LSB first.
module pio_uart_cmd_tx
  import wifi_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cmd_word,
  output logic        txd,
  output logic        busy,
  output logic        ack_toggle,
  output logic [7:0]  tx_count,
  output logic [31:0] status_word
);

  state_e               state_q, state_d;
  logic [PAYLOAD_W-1:0] shift_q, shift_d;
  logic [1:0]           bytes_left_q, bytes_left_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 req_tog_q, req_tog_d;
  logic                 ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic                 txd_q, txd_d;
  logic [7:0]           tx_count_q, tx_count_d;
  logic                 tick;
  logic                 unused_cmd;

  assign unused_cmd = ^cmd_word[30:26];

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (state_q == IDLE),
    .en     (state_q != IDLE),
    .tick   (tick)
  );

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bytes_left_d = bytes_left_q;
    bit_idx_d    = bit_idx_q;
    req_tog_d    = req_tog_q;
    ack_d        = ack_q;
    busy_d       = busy_q;
    txd_d        = txd_q;
    tx_count_d   = tx_count_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_word[REQ_BIT] != ack_q) begin
          shift_d      = cmd_word[PAYLOAD_W-1:0];
          bytes_left_d = clamp_count(cmd_word[CNT_HI:CNT_LO]);
          req_tog_d    = cmd_word[REQ_BIT];
          bit_idx_d    = '0;
          busy_d       = 1'b1;
          txd_d        = 1'b0;
          state_d      = START;
        end
      end
      START: begin
        if (tick) begin
          bit_idx_d = '0;
          txd_d     = shift_q[0];
          state_d   = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          // Shifting on all eight bit ends leaves the next byte in [7:0] for free.
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shift_q[1];
          end
        end
      end
      STOP: begin
        if (tick) begin
          tx_count_d = tx_count_q + 8'd1;
          if (bytes_left_q != 2'd0) begin
            bytes_left_d = bytes_left_q - 2'd1;
            txd_d        = 1'b0;
            state_d      = START;
          end else begin
            busy_d  = 1'b0;
            ack_d   = req_tog_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bytes_left_q <= '0;
      bit_idx_q    <= '0;
      req_tog_q    <= 1'b0;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      txd_q        <= 1'b1;
      tx_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bytes_left_q <= bytes_left_d;
      bit_idx_q    <= bit_idx_d;
      req_tog_q    <= req_tog_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      txd_q        <= txd_d;
      tx_count_q   <= tx_count_d;
    end
  end

  assign txd        = txd_q;
  assign busy       = busy_q;
  assign ack_toggle = ack_q;
  assign tx_count   = tx_count_q;

  always_comb begin
    status_word                  = '0;
    status_word[STATUS_BUSY_BIT] = busy_q;
    status_word[STATUS_ACK_BIT]  = ack_q;
    status_word[7:0]             = tx_count_q;
  end

endmodule
